// File: rtl/morse_pkg.sv
// Shared symbol codes, unit counts and FSM state type for the Morse servo sequencer.
package morse_pkg;

    // Symbol encodings on sym_code (2-bit, every value is a legal symbol)
    localparam logic [1:0] SYM_DOT  = 2'b00;
    localparam logic [1:0] SYM_DASH = 2'b01;
    localparam logic [1:0] SYM_LGAP = 2'b10;
    localparam logic [1:0] SYM_WGAP = 2'b11;

    // Duration of each timed state, in Morse units
    localparam logic [2:0] DOT_UNITS   = 3'd1;
    localparam logic [2:0] DASH_UNITS  = 3'd3;
    localparam logic [2:0] SPACE_UNITS = 3'd1;
    localparam logic [2:0] LGAP_UNITS  = 3'd2;
    localparam logic [2:0] WGAP_UNITS  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_SPACE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Unit timer: a cycle counter that wraps every UNIT_CYCLES cycles (unit_tick)
// and a units_left down-counter loaded on each state entry.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_clear,
    input  logic       i_abort,
    output logic       o_unit_tick,
    output logic       o_expire
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] r_cyc_cnt;
    logic [2:0]    r_units_left;

    assign o_unit_tick = (r_cyc_cnt == LAST_CYC);
    // Final unit of the current state is in progress; the FSM exits on the tick.
    assign o_expire    = (r_units_left == 3'd1);

    // Counter update: abort/clear zero everything, load restarts phase, tick consumes a unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt    <= '0;
            r_units_left <= '0;
        end else if (i_abort || i_clear) begin
            r_cyc_cnt    <= '0;
            r_units_left <= '0;
        end else if (i_load) begin
            r_cyc_cnt    <= '0;
            r_units_left <= i_load_val;
        end else if (o_unit_tick) begin
            r_cyc_cnt    <= '0;
            r_units_left <= r_units_left - 3'd1;
        end else begin
            r_cyc_cnt    <= r_cyc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_servo_sequencer.sv
// Morse servo sequencer: accepts one symbol per valid/ready handshake and
// drives the servo angle to key dots and dashes with standard Morse timing.
// Handshake: a symbol is taken on a clk edge where sym_valid && sym_ready;
// sym_ready is high only in IDLE with abort low, and sym_code is sampled only then.
module morse_servo_sequencer
    import morse_pkg::*;
#(
    parameter int         UNIT_CYCLES = 5_000_000,
    parameter logic [7:0] PRESS_ANGLE = 8'd45,
    parameter logic [7:0] REST_ANGLE  = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [1:0] sym_code,
    output logic       sym_ready,
    input  logic       abort,
    output logic [7:0] angle,
    output logic       busy,
    output logic       sym_done,
    output state_t     dbg_state
);

    state_t     r_state;
    state_t     w_next;
    logic       w_load;
    logic [2:0] w_load_val;
    logic       w_clear;
    logic       w_done;
    logic       w_unit_tick;
    logic       w_expire;
    logic       w_exit;
    logic [7:0] r_angle;
    logic       r_busy;
    logic       r_sym_done;

    assign sym_ready = (r_state == ST_IDLE) && !abort;
    assign w_exit    = w_unit_tick && w_expire;
    // Counters sit at zero whenever the FSM is (or is about to be) idle
    assign w_clear   = (w_next == ST_IDLE);
    assign angle     = r_angle;
    assign busy      = r_busy;
    assign sym_done  = r_sym_done;
    assign dbg_state = r_state;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_clear    (w_clear),
        .i_abort    (abort),
        .o_unit_tick(w_unit_tick),
        .o_expire   (w_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic, timer load requests and completion detection
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = 3'd0;
        w_done     = 1'b0;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sym_valid) begin
                        w_load = 1'b1;
                        case (sym_code)
                            SYM_DOT:  begin w_next = ST_PRESS; w_load_val = DOT_UNITS;  end
                            SYM_DASH: begin w_next = ST_PRESS; w_load_val = DASH_UNITS; end
                            SYM_LGAP: begin w_next = ST_GAP;   w_load_val = LGAP_UNITS; end
                            default:  begin w_next = ST_GAP;   w_load_val = WGAP_UNITS; end
                        endcase
                    end
                end
                ST_PRESS: begin
                    if (w_exit) begin
                        w_next     = ST_SPACE;
                        w_load     = 1'b1;
                        w_load_val = SPACE_UNITS;
                    end
                end
                ST_SPACE, ST_GAP: begin
                    if (w_exit) begin
                        w_next = ST_IDLE;
                        w_done = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Registered outputs follow the state being entered, so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_angle    <= REST_ANGLE;
            r_busy     <= 1'b0;
            r_sym_done <= 1'b0;
        end else begin
            r_angle    <= (w_next == ST_PRESS) ? PRESS_ANGLE : REST_ANGLE;
            r_busy     <= (w_next != ST_IDLE);
            r_sym_done <= w_done;
        end
    end

endmodule
